// File: rtl/dwc_pair_scheduler.sv
// Round-robin scheduler sharing one DWC comparator among N lockstep core pairs, with retry/fault policy.
// Optional per-pair mismatch statistics when DWC_SCHED_STATS_EN is defined.
module dwc_pair_scheduler #(
    parameter int N_PAIRS   = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_RETRY = 3,
    parameter int ACK_TMO   = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_PAIRS-1:0]        req_valid_i,
    input  logic [N_PAIRS*DATA_W-1:0] data_a_i,
    input  logic [N_PAIRS*DATA_W-1:0] data_b_i,
    output logic [N_PAIRS-1:0]        req_ready_o,
    output logic [N_PAIRS-1:0]        resp_valid_o,
    output logic                      resp_match_o,
    output logic                      resp_retry_o,
    input  logic [N_PAIRS-1:0]        resp_ack_i,
    output logic [N_PAIRS-1:0]        fault_o,
    input  logic [N_PAIRS-1:0]        fault_clr_i,
    output logic                      irq_o
`ifdef DWC_SCHED_STATS_EN
    ,
    input  logic [$clog2(N_PAIRS)-1:0] stat_sel_i,
    output logic [15:0]                stat_cnt_o
`endif
);

    localparam int PTR_W = $clog2(N_PAIRS);
    localparam int CNT_W = $clog2(MAX_RETRY + 1);
    localparam int TMR_W = $clog2(ACK_TMO + 1);

    typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

    state_t              state_q;
    logic [PTR_W-1:0]    rr_ptr_q, grant_q;
    logic [DATA_W-1:0]   a_q, b_q;
    logic [CNT_W-1:0]    retry_q [N_PAIRS];
    logic [TMR_W-1:0]    tmr_q;
    logic [N_PAIRS-1:0]  req_ready_q, resp_valid_q, fault_q;
    logic                resp_match_q, resp_retry_q, irq_q;

    logic [N_PAIRS-1:0]   elig;
    logic [2*N_PAIRS-1:0] elig2;
    logic [PTR_W-1:0]     g_sel;

    assign elig  = req_valid_i & ~fault_q;
    assign elig2 = {elig, elig};

    // Scan downward so the eligible pair closest to rr_ptr is the last one written.
    always_comb begin
        g_sel = '0;
        for (int k = N_PAIRS - 1; k >= 0; k--) begin
            if (elig2[int'(rr_ptr_q) + k])
                g_sel = PTR_W'((int'(rr_ptr_q) + k) % N_PAIRS);
        end
    end

`ifdef DWC_SCHED_STATS_EN
    logic [15:0] stat_q [N_PAIRS];
    assign stat_cnt_o = stat_q[stat_sel_i];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            a_q          <= '0;
            b_q          <= '0;
            tmr_q        <= '0;
            req_ready_q  <= '0;
            resp_valid_q <= '0;
            fault_q      <= '0;
            resp_match_q <= 1'b0;
            resp_retry_q <= 1'b0;
            irq_q        <= 1'b0;
            for (int i = 0; i < N_PAIRS; i++) begin
                retry_q[i] <= '0;
`ifdef DWC_SCHED_STATS_EN
                stat_q[i]  <= '0;
`endif
            end
        end else begin
            irq_q <= (|resp_valid_q) | (|fault_q);

            // Clears come first so a fault set later in this block takes priority.
            for (int i = 0; i < N_PAIRS; i++) begin
                if (fault_clr_i[i]) begin
                    fault_q[i] <= 1'b0;
                    retry_q[i] <= '0;
`ifdef DWC_SCHED_STATS_EN
                    stat_q[i]  <= '0;
`endif
                end
            end

            case (state_q)
                IDLE: begin
                    if (|elig) begin
                        a_q                <= data_a_i[int'(g_sel)*DATA_W +: DATA_W];
                        b_q                <= data_b_i[int'(g_sel)*DATA_W +: DATA_W];
                        grant_q            <= g_sel;
                        rr_ptr_q           <= PTR_W'((int'(g_sel) + 1) % N_PAIRS);
                        req_ready_q[g_sel] <= 1'b1;
                        state_q            <= CMP;
                    end
                end
                CMP: begin
                    req_ready_q <= '0;
                    if (a_q == b_q) begin
                        retry_q[grant_q] <= '0;
                        resp_match_q     <= 1'b1;
                        resp_retry_q     <= 1'b0;
                    end else begin
                        resp_match_q <= 1'b0;
                        if (int'(retry_q[grant_q]) < MAX_RETRY - 1) begin
                            retry_q[grant_q] <= retry_q[grant_q] + 1'b1;
                            resp_retry_q     <= 1'b1;
                        end else begin
                            retry_q[grant_q] <= '0;
                            fault_q[grant_q] <= 1'b1;
                            resp_retry_q     <= 1'b0;
                        end
`ifdef DWC_SCHED_STATS_EN
                        if (stat_q[grant_q] != 16'hFFFF)
                            stat_q[grant_q] <= stat_q[grant_q] + 16'd1;
`endif
                    end
                    resp_valid_q[grant_q] <= 1'b1;
                    tmr_q                 <= TMR_W'(ACK_TMO);
                    state_q               <= RESP;
                end
                RESP: begin
                    if (resp_ack_i[grant_q]) begin
                        resp_valid_q[grant_q] <= 1'b0;
                        state_q               <= IDLE;
                    end else if (tmr_q == '0) begin
                        resp_valid_q[grant_q] <= 1'b0;
                        fault_q[grant_q]      <= 1'b1;
                        state_q               <= IDLE;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_match_o = resp_match_q;
    assign resp_retry_o = resp_retry_q;
    assign fault_o      = fault_q;
    assign irq_o        = irq_q;

endmodule

// File: tb/tb_dwc_pair_scheduler.sv
// Scoreboard bench for dwc_pair_scheduler: expected responses queued at send time, popped on grant.
module tb_dwc_pair_scheduler;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MR = 3;
    localparam int TMO = 255;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] data_a = '0, data_b = '0;
    logic [N-1:0]   req_ready, resp_valid, fault;
    logic           resp_match, resp_retry, irq;
    logic [N-1:0]   resp_ack = '0, fault_clr = '0;

    dwc_pair_scheduler #(.N_PAIRS(N), .DATA_W(W), .MAX_RETRY(MR), .ACK_TMO(TMO)) dut (
        .clk(clk), .reset(reset), .req_valid_i(req_valid), .data_a_i(data_a), .data_b_i(data_b),
        .req_ready_o(req_ready), .resp_valid_o(resp_valid), .resp_match_o(resp_match),
        .resp_retry_o(resp_retry), .resp_ack_i(resp_ack), .fault_o(fault),
        .fault_clr_i(fault_clr), .irq_o(irq));

    always #5 clk = ~clk;

    typedef struct {
        int pair;
        bit match;
        bit retry;
        bit flt;
    } exp_t;

    exp_t exp_q[$];
    int   m_cnt[N];
    int   n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Drive pair p's operands and queue the response the spec's retry policy predicts.
    task automatic send(input int p, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        data_a[p*W +: W] = a;
        data_b[p*W +: W] = b;
        req_valid[p] = 1'b1;
        e.pair = p;
        if (a == b) begin
            m_cnt[p] = 0; e.match = 1; e.retry = 0; e.flt = 0;
        end else if (m_cnt[p] < MR - 1) begin
            m_cnt[p]++;   e.match = 0; e.retry = 1; e.flt = 0;
        end else begin
            m_cnt[p] = 0; e.match = 0; e.retry = 0; e.flt = 1;
        end
        exp_q.push_back(e);
    endtask

    task automatic serve(input bit hold, input bit ack);
        exp_t e;
        bit   got = 0;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin got = 1; break; end
        end
        check("grant_seen", got, 1);
        if (!got) return;
        check("req_ready", req_ready, 1 << e.pair);
        if (!hold) req_valid[e.pair] = 1'b0;
        @(negedge clk);
        check("ready_pulse", req_ready, 0);
        check("resp_valid", resp_valid, 1 << e.pair);
        check("resp_match", resp_match, e.match);
        check("resp_retry", resp_retry, e.retry);
        check("fault_bit", fault[e.pair], e.flt);
        if (ack) begin
            resp_ack[e.pair] = 1'b1;
            @(negedge clk);
            resp_ack = '0;
            check("resp_cleared", resp_valid, 0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0; resp_ack = '0; fault_clr = '0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int cyc;
        bit any_rdy;
        int seen;

        do_reset();
        check("rst_ready", req_ready, 0);
        check("rst_valid", resp_valid, 0);
        check("rst_fault", fault, 0);
        check("rst_irq", irq, 0);
        check("rst_match", resp_match, 0);
        check("rst_retry", resp_retry, 0);

        // Round robin with all pairs requesting continuously: 0,1,2,3,0.
        for (int p = 0; p < N; p++) begin
            data_a[p*W +: W] = 32'h100 + p;
            data_b[p*W +: W] = 32'h100 + p;
        end
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            exp_t e;
            e.pair = k % N; e.match = 1; e.retry = 0; e.flt = 0;
            exp_q.push_back(e);
        end
        for (int k = 0; k < 5; k++) serve(1, 1);
        req_valid = '0;

        do_reset();
        send(0, 32'hDEADBEEF, 32'hDEADBEEF);
        serve(0, 1);

        // Pair 2 escalates to fault on its third consecutive mismatch.
        repeat (3) begin
            send(2, 32'h1, 32'h3);
            serve(0, 1);
        end
        check("p2_fault", fault, 4'b0100);
        check("p2_irq", irq, 1);

        req_valid[2] = 1'b1;
        any_rdy = 0;
        repeat (10) begin
            @(negedge clk);
            any_rdy |= (req_ready != '0);
        end
        req_valid[2] = 1'b0;
        check("p2_masked", any_rdy, 0);

        fault_clr[2] = 1'b1;
        @(negedge clk);
        fault_clr = '0;
        check("p2_cleared", fault, 0);
        @(negedge clk);
        check("irq_drop", irq, 0);
        send(2, 32'h1, 32'h3);
        serve(0, 1);
        send(2, 32'h5, 32'h5);
        serve(0, 1);
        send(2, 32'h1, 32'h3);
        serve(0, 1);
        send(2, 32'h1, 32'h3);
        serve(0, 1);

        // Ack timeout on pair 1 while other ack bits are asserted.
        send(1, 32'h7, 32'h7);
        serve(0, 0);
        resp_ack = 4'b1101;
        seen = 1;
        cyc = 0;
        while (cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (resp_valid[1]) seen++;
            else break;
        end
        resp_ack = '0;
        check("tmo_len", seen, TMO + 1);
        check("tmo_fault", fault, 4'b0010);
        check("tmo_valid", resp_valid, 0);
        send(0, 32'hA5A5A5A5, 32'hA5A5A5A5);
        serve(0, 1);

        // Reset during RESP aborts everything.
        send(3, 32'h9, 32'h9);
        serve(0, 0);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", resp_valid, 0);
        check("mid_rst_fault", fault, 0);
        check("mid_rst_irq", irq, 0);
        check("mid_rst_ready", req_ready, 0);
        check("mid_rst_match", resp_match, 0);
        do_reset();
        send(0, 32'h1, 32'h2);
        serve(0, 1);

        check("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
